// File: rtl/oam_dma_controller_if.sv
// ============================================================================
// Module      : oam_dma_controller_if
// Description : CPU-side and memory-map-side bus bundle for the OAM DMA block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface oam_dma_controller_if;
   logic [15:0] cpu_addr;
   logic        cpu_wren;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic        mem_wren;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        dma_active;
   logic        dma_done;

   modport slave (
      input  cpu_addr, cpu_wren, cpu_wdata, mem_rdata,
      output cpu_rdata, mem_addr, mem_wren, mem_wdata, dma_active, dma_done
   );

   modport master (
      output cpu_addr, cpu_wren, cpu_wdata, mem_rdata,
      input  cpu_rdata, mem_addr, mem_wren, mem_wdata, dma_active, dma_done
   );
endinterface

`default_nettype wire

// File: rtl/oam_dma_controller.sv
// ============================================================================
// Module      : oam_dma_controller
// Description : Game Boy OAM DMA sequencer and CPU/DMA memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_dma_controller #(
   parameter int          XFER_LEN     = 160,
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] OAM_BASE     = 16'hFE00
) (
   input wire                    clock,
   input wire                    reset,
   oam_dma_controller_if.slave   bus
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_READ  = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_WRITE = 2'd3;
   localparam logic [7:0] c_LAST_IDX = 8'(XFER_LEN - 1);

   logic [1:0] r_state;
   logic [1:0] w_next_state;
   logic [7:0] r_src;
   logic [7:0] r_idx;
   logic [7:0] r_data;
   logic       r_active;
   logic       r_done;

   logic       w_reg_hit;
   logic       w_trig;
   logic       w_last;
   logic [7:0] w_eff_hi;

   assign w_reg_hit = (bus.cpu_addr == DMA_REG_ADDR);
   assign w_trig    = bus.cpu_wren && w_reg_hit;
   assign w_last    = (r_idx == c_LAST_IDX);
   // E0-FF sources alias onto C000-DFFF work RAM (echo region)
   assign w_eff_hi  = (r_src >= 8'hE0) ? (r_src & 8'hDF) : r_src;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:  w_next_state = c_IDLE;
         c_READ:  w_next_state = c_WAIT;
         c_WAIT:  w_next_state = c_WRITE;
         c_WRITE: w_next_state = w_last ? c_IDLE : c_READ;
         default: w_next_state = c_IDLE;
      endcase
      // A register write starts (or restarts) a transfer from any state
      if (w_trig) begin
         w_next_state = c_READ;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= c_IDLE;
         r_src    <= 8'h00;
         r_idx    <= 8'h00;
         r_data   <= 8'h00;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_active <= (w_next_state != c_IDLE);
         r_done   <= (r_state == c_WRITE) && w_last && !w_trig;
         if (w_trig) begin
            r_src <= bus.cpu_wdata;
            r_idx <= 8'h00;
         end else if ((r_state == c_WRITE) && !w_last) begin
            r_idx <= r_idx + 8'h01;
         end
         if (r_state == c_WAIT) begin
            r_data <= bus.mem_rdata;
         end
      end
   end

   always_comb begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wren  = bus.cpu_wren;
      bus.mem_wdata = bus.cpu_wdata;
      bus.cpu_rdata = w_reg_hit ? r_src : bus.mem_rdata;
      case (r_state)
         c_READ, c_WAIT: begin
            bus.mem_addr  = {w_eff_hi, r_idx};
            bus.mem_wren  = 1'b0;
            bus.mem_wdata = r_data;
            bus.cpu_rdata = w_reg_hit ? r_src : 8'hFF;
         end
         c_WRITE: begin
            bus.mem_addr  = OAM_BASE + {8'h00, r_idx};
            bus.mem_wren  = 1'b1;
            bus.mem_wdata = r_data;
            bus.cpu_rdata = w_reg_hit ? r_src : 8'hFF;
         end
         default: begin
            bus.mem_addr  = bus.cpu_addr;
         end
      endcase
   end

   assign bus.dma_active = r_active;
   assign bus.dma_done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
// ============================================================================
// Module      : tb_oam_dma_controller
// Description : Scoreboard bench for oam_dma_controller with a 64 KiB memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oam_dma_controller;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   oam_dma_controller_if bus();

   oam_dma_controller dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Memory map: registered read, so data is valid the cycle after the address
   logic [7:0] mem [0:65535];
   logic [7:0] rd_q = 8'h00;
   assign bus.mem_rdata = rd_q;
   always @(posedge clock) begin
      rd_q <= mem[bus.mem_addr];
      if (bus.mem_wren) mem[bus.mem_addr] = bus.mem_wdata;
   end

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      int          at;
   } wr_t;

   wr_t wq[$];
   int  dq[$];
   int  checks = 0;
   int  errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int kind, input int i);
      logic [7:0] b;
      b = 8'(i);
      case (kind)
         0:       return b ^ 8'h5A;
         1:       return b ^ 8'hA5;
         default: return ~b;
      endcase
   endfunction

   task automatic push_xfer(input int kind, input int t0, input int count);
      wr_t e;
      for (int i = 0; i < count; i++) begin
         e.addr = 16'hFE00 + 16'(i);
         e.data = exp_byte(kind, i);
         e.at   = t0 + 3 + 3 * i;
         wq.push_back(e);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
      bus.cpu_addr  = a;
      bus.cpu_wren  = w;
      bus.cpu_wdata = d;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clock);
   endtask

   // Monitor: every DMA-owned write and every done pulse must match the next expectation
   always begin
      wr_t e;
      @(negedge clock);
      #2;
      if (bus.dma_active && bus.mem_wren) begin
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dma_write: addr %0h data %0h cycle %0d", bus.mem_addr, bus.mem_wdata, cyc);
         end else begin
            e = wq.pop_front();
            chk("dma_wr_addr", 32'(bus.mem_addr), 32'(e.addr));
            chk("dma_wr_data", 32'(bus.mem_wdata), 32'(e.data));
            chk("dma_wr_cycle", 32'(cyc), 32'(e.at));
         end
      end
      if (bus.dma_done) begin
         if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dma_done: cycle %0d", cyc);
         end else begin
            chk("dma_done_cycle", 32'(cyc), 32'(dq.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int t1;
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      for (int i = 0; i < 160; i++) begin
         mem[16'hC100 + 16'(i)] = exp_byte(0, i);
         mem[16'hD000 + 16'(i)] = exp_byte(1, i);
         mem[16'hD300 + 16'(i)] = exp_byte(2, i);
         mem[16'hF300 + 16'(i)] = 8'h11;
      end
      mem[16'h8000] = 8'h3C;

      // Reset held: pass-through, outputs idle
      drive(16'h1234, 1'b1, 8'h99);
      repeat (2) @(negedge clock);
      #1;
      chk("rst_active", 32'(bus.dma_active), 0);
      chk("rst_done", 32'(bus.dma_done), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'h1234);
      chk("rst_mem_wren", 32'(bus.mem_wren), 1);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h99);

      @(negedge clock);
      reset = 1'b1;
      drive(16'hFF46, 1'b0, 8'h00);
      #1;
      chk("ff46_after_reset", 32'(bus.cpu_rdata), 0);
      chk("idle_wren", 32'(bus.mem_wren), 0);
      @(negedge clock);
      drive(16'h8000, 1'b0, 8'h00);
      #1;
      chk("idle_addr", 32'(bus.mem_addr), 32'h8000);
      @(negedge clock);
      drive(16'h0000, 1'b0, 8'h00);
      #1;
      chk("idle_read_8000", 32'(bus.cpu_rdata), 32'h3C);

      // Full transfer from C100 with CPU traffic during it
      @(negedge clock);
      t0 = cyc;
      push_xfer(0, t0, 160);
      dq.push_back(t0 + 481);
      drive(16'hFF46, 1'b1, 8'hC1);
      @(negedge clock);
      drive(16'h0000, 1'b0, 8'h00);
      #1;
      chk("t1_active", 32'(bus.dma_active), 1);
      chk("t1_read_addr", 32'(bus.mem_addr), 32'hC100);
      chk("t1_wren", 32'(bus.mem_wren), 0);
      wait_cyc(t0 + 10);
      drive(16'hC000, 1'b1, 8'h77);
      #1;
      chk("busy_write_dropped", 32'(bus.mem_wren), 0);
      @(negedge clock);
      drive(16'h8000, 1'b0, 8'h00);
      #1;
      chk("busy_read_ff", 32'(bus.cpu_rdata), 32'hFF);
      @(negedge clock);
      drive(16'hFF46, 1'b0, 8'h00);
      #1;
      chk("busy_reg_read", 32'(bus.cpu_rdata), 32'hC1);
      @(negedge clock);
      drive(16'h0000, 1'b0, 8'h00);
      wait_cyc(t0 + 480);
      #1;
      chk("last_active", 32'(bus.dma_active), 1);
      chk("last_addr", 32'(bus.mem_addr), 32'hFE9F);
      @(negedge clock);
      drive(16'h4321, 1'b0, 8'h00);
      #1;
      chk("end_inactive", 32'(bus.dma_active), 0);
      chk("end_passthru", 32'(bus.mem_addr), 32'h4321);
      chk("c000_untouched", 32'(mem[16'hC000]), 0);

      // Restart at idx 50 with source D0
      @(negedge clock);
      t0 = cyc;
      push_xfer(0, t0, 50);
      drive(16'hFF46, 1'b1, 8'hC1);
      @(negedge clock);
      drive(16'h0000, 1'b0, 8'h00);
      wait_cyc(t0 + 151);
      #1;
      chk("restart_pre_addr", 32'(bus.mem_addr), 32'hC132);
      t1 = cyc;
      push_xfer(1, t1, 160);
      dq.push_back(t1 + 481);
      drive(16'hFF46, 1'b1, 8'hD0);
      @(negedge clock);
      drive(16'h0000, 1'b0, 8'h00);
      #1;
      chk("restart_read_addr", 32'(bus.mem_addr), 32'hD000);
      wait_cyc(t1 + 480);
      #1;
      chk("restart_last_active", 32'(bus.dma_active), 1);
      @(negedge clock);
      #1;
      chk("restart_end_inactive", 32'(bus.dma_active), 0);

      // Echo source F3, then retrigger exactly on the final WRITE
      @(negedge clock);
      t0 = cyc;
      push_xfer(2, t0, 160);
      drive(16'hFF46, 1'b1, 8'hF3);
      @(negedge clock);
      drive(16'h0000, 1'b0, 8'h00);
      #1;
      chk("echo_read_addr", 32'(bus.mem_addr), 32'hD300);
      wait_cyc(t0 + 480);
      #1;
      chk("coinc_final_addr", 32'(bus.mem_addr), 32'hFE9F);
      t1 = cyc;
      push_xfer(0, t1, 160);
      dq.push_back(t1 + 481);
      drive(16'hFF46, 1'b1, 8'hC1);
      @(negedge clock);
      drive(16'h0000, 1'b0, 8'h00);
      #1;
      chk("coinc_active", 32'(bus.dma_active), 1);
      chk("coinc_read_addr", 32'(bus.mem_addr), 32'hC100);
      wait_cyc(t1 + 481);
      #1;
      chk("coinc_end_inactive", 32'(bus.dma_active), 0);

      // Asynchronous reset at idx 80
      @(negedge clock);
      for (int i = 0; i < 80; i++) mem[16'hFE50 + 16'(i)] = 8'h00;
      t0 = cyc;
      push_xfer(0, t0, 80);
      drive(16'hFF46, 1'b1, 8'hC1);
      @(negedge clock);
      drive(16'h0000, 1'b0, 8'h00);
      wait_cyc(t0 + 241);
      #1;
      chk("rstmid_pre_addr", 32'(bus.mem_addr), 32'hC150);
      reset = 1'b0;
      drive(16'h1234, 1'b1, 8'hAB);
      #1;
      chk("rstmid_active", 32'(bus.dma_active), 0);
      chk("rstmid_wren", 32'(bus.mem_wren), 1);
      chk("rstmid_addr", 32'(bus.mem_addr), 32'h1234);
      @(negedge clock);
      reset = 1'b1;
      drive(16'h0000, 1'b0, 8'h00);
      repeat (500) @(negedge clock);
      #3;
      chk("rstmid_fe50", 32'(mem[16'hFE50]), 0);
      chk("rstmid_fe9f", 32'(mem[16'hFE9F]), 0);
      chk("writes_outstanding", 32'(wq.size()), 0);
      chk("dones_outstanding", 32'(dq.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
